// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one SRAM word read per cycle, buffers {instr, pc} in a FIFO.
// Optional pop counter on perf_fetch_cnt_o when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0004,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [31:0]   pend_pc;
  logic          pend;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic          pop;
  logic          push;
  logic [CW:0]   occ;

  assign pop  = instr_valid_o & instr_ready_i;
  assign push = pend & ~redirect_i;

  // Slots already promised to buffered or in-flight words; a pop this cycle frees one.
  assign occ = {1'b0, count} + (CW+1)'(pend) - (CW+1)'(pop);

  assign mem_req_o   = rst_ni & ~redirect_i & (occ < (CW+1)'(DEPTH));
  assign mem_we_o    = 1'b0;
  assign mem_wdata_o = 32'h0;
  assign mem_addr_o  = {2'b00, pc[31:2]};

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr] : 32'h0;
  assign instr_pc_o    = instr_valid_o ? fifo_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= 32'h0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      pend <= mem_req_o;
      if (mem_req_o) begin
        pc      <= pc + 32'd4;
        pend_pc <= pc;
      end
      if (redirect_i) begin
        pc     <= redirect_pc_i & ~32'h3;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem_rdata_i;
      fifo_pc[wr_ptr]    <= pend_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_cnt_o <= 32'h0;
    end else if (pop) begin
      perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
    end
  end
`else
  // Counter absent in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a single-cycle SRAM model; perf counter checked when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0004), .DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o (perf_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd1:   return 32'h002081B3;
      32'd2:   return 32'h40520333;
      32'd3:   return 32'h0083F4B3;
      32'd6:   return 32'h000186B3;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  always @(posedge clk) mem_rdata <= mem_req ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({mem_req, instr_valid, instr, instr_pc} !== 66'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {mem_req, instr_valid, instr, instr_pc});
    end
    checks++;
    if ({mem_we, mem_wdata} !== 33'h0) begin
      errors++;
      $display("FAIL reset_write_side got %h exp 0", {mem_we, mem_wdata});
    end
    checks++;
    if (mem_addr !== 32'd1) begin
      errors++;
      $display("FAIL reset_pc_addr got %h exp 1", mem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_a [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    logic        exp_v [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_i [5] = '{32'h0, 32'h0, 32'h002081B3, 32'h40520333, 32'h0083F4B3};
    logic [31:0] exp_p [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    rst_ni      = 1'b1;
    instr_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, exp_a[c]}) begin
        errors++;
        $display("FAIL stream_req c%0d got %h exp %h", c, {mem_req, mem_addr}, {1'b1, exp_a[c]});
      end
      checks++;
      if ({instr_valid, instr, instr_pc} !== {exp_v[c], exp_i[c], exp_p[c]}) begin
        errors++;
        $display("FAIL stream_head c%0d got %h exp %h", c, {instr_valid, instr, instr_pc},
                 {exp_v[c], exp_i[c], exp_p[c]});
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    logic [31:0] exp_i [4] = '{32'h002081B3, 32'h40520333, 32'h0083F4B3, 32'hA5A50004};
    do_reset();
    rst_ni = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (mem_req) begin
        checks++;
        if (mem_addr !== 32'(nreq + 1)) begin
          errors++;
          $display("FAIL bp_addr c%0d got %h exp %h", c, mem_addr, 32'(nreq + 1));
        end
        nreq++;
      end
      tick();
    end
    #1;
    checks++;
    if (nreq !== 2 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_req_count got %0d req %b exp 2 req 0", nreq, mem_req);
    end
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h002081B3, 32'h4}) begin
      errors++;
      $display("FAIL bp_hold got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'h002081B3, 32'h4});
    end
    tick();
    instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, exp_i[c], 32'(4 * (c + 1))}) begin
        errors++;
        $display("FAIL bp_drain c%0d got %h exp %h", c, {instr_valid, instr, instr_pc},
                 {1'b1, exp_i[c], 32'(4 * (c + 1))});
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h18;
    #1;
    checks++;
    if ({mem_req, instr_valid, instr} !== {1'b0, 1'b1, 32'h002081B3}) begin
      errors++;
      $display("FAIL rf_k got %h exp %h", {mem_req, instr_valid, instr}, {1'b0, 1'b1, 32'h002081B3});
    end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'd6, 1'b0}) begin
      errors++;
      $display("FAIL rf_k1 got %h exp %h", {mem_req, mem_addr, instr_valid}, {1'b1, 32'd6, 1'b0});
    end
    tick();
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rf_k2_valid got %b exp 0", instr_valid);
    end
    tick();
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h000186B3, 32'h18}) begin
      errors++;
      $display("FAIL rf_k3 got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'h000186B3, 32'h18});
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    rst_ni      = 1'b1;
    instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h1B;
    #1;
    checks++;
    if ({mem_req, instr_valid, instr, instr_pc} !== {1'b0, 1'b1, 32'h0083F4B3, 32'hC}) begin
      errors++;
      $display("FAIL rp_k got %h exp %h", {mem_req, instr_valid, instr, instr_pc},
               {1'b0, 1'b1, 32'h0083F4B3, 32'hC});
    end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'd6, 1'b0}) begin
      errors++;
      $display("FAIL rp_k1 got %h exp %h", {mem_req, mem_addr, instr_valid}, {1'b1, 32'd6, 1'b0});
    end
    tick();
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_k2_valid got %b exp 0", instr_valid);
    end
    tick();
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h000186B3, 32'h18}) begin
      errors++;
      $display("FAIL rp_k3 got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'h000186B3, 32'h18});
    end
    tick();
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hA5A50007, 32'h1C}) begin
      errors++;
      $display("FAIL rp_k4 got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'hA5A50007, 32'h1C});
    end
    tick();
    instr_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    #1;
    checks++;
    if (perf_cnt !== 32'd5) begin
      errors++;
      $display("FAIL perf_count got %0d exp 5", perf_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    rst_ni      = 1'b1;
    instr_ready = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h3FFF_FFFF}) begin
      errors++;
      $display("FAIL wrap_addr_hi got %h exp %h", {mem_req, mem_addr}, {1'b1, 32'h3FFF_FFFF});
    end
    tick();
    #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_addr_lo got %h exp %h", {mem_req, mem_addr}, {1'b1, 32'h0});
    end
    tick();
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hA5A5FFFF, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_head_hi got %h exp %h", {instr_valid, instr, instr_pc},
               {1'b1, 32'hA5A5FFFF, 32'hFFFF_FFFC});
    end
    tick();
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hA5A50000, 32'h0}) begin
      errors++;
      $display("FAIL wrap_head_lo got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'hA5A50000, 32'h0});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rst_ni      = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({instr_valid, mem_req, instr} !== 34'h0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", {instr_valid, mem_req, instr});
    end
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL restart_addr got %h exp %h", {mem_req, mem_addr}, {1'b1, 32'd1});
    end
    tick();
    tick();
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h002081B3, 32'h4}) begin
      errors++;
      $display("FAIL restart_head got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'h002081B3, 32'h4});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
